fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage directly downstream of program_counter.
- Takes the current PC, issues word fetches to instruction memory over a request/grant bus, and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Backpressures the PC via pc_ready. Supports flush on branch/jump redirect; responses already in flight are discarded.

Parameters:
- DEPTH, 2, FIFO entries and maximum in-flight credit (outstanding requests + occupancy ≤ DEPTH); power of two, ≥ 2.
- XLEN, 32, address/instruction width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  XLEN  fetch address from program_counter.
- pc_valid  input  1  pc_in is valid for fetch.
- pc_ready  output  1  pc_in accepted this cycle (imem_req & imem_gnt); PC may advance.
- flush  input  1  redirect; discard all buffered and in-flight fetches.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch address, equal to {pc_in[XLEN-1:2],2'b00}.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, latency ≥ 1 cycle after grant.
- imem_rdata  input  XLEN  instruction word.
- if_valid  output  1  if_instr/if_pc valid to decode.
- if_ready  input  1  decode accepts this cycle.
- if_instr  output  XLEN  instruction at FIFO head.
- if_pc  output  XLEN  PC of if_instr.

Behaviour:
- Reset (synchronous, active-high): FIFO empty, outstanding=0, discard=0, PC-tag queue empty. imem_req=0, if_valid=0, pc_ready=0. if_instr and if_pc reset to 0.
- Credit: credits = DEPTH − occupancy − outstanding.
- imem_req = pc_valid & !flush & !reset & (credits > 0). Combinational; imem_addr follows pc_in.
- On a grant (imem_req & imem_gnt):
  - push pc_in into the internal PC-tag queue (DEPTH deep);
  - outstanding += 1;
  - pc_ready = 1 in the same cycle.
- On a response (imem_rvalid):
  - if discard > 0: drop the response, discard −= 1, outstanding −= 1;
  - else: pop the PC-tag queue, write {imem_rdata, tag} to the FIFO tail, outstanding −= 1.
- Grant and response in the same cycle: outstanding unchanged; both tag push and pop occur.
- Dequeue: occurs when if_valid & if_ready; head advances next edge. if_valid = (occupancy > 0).
- Latency: grant at cycle N, rvalid at cycle N+L → if_valid at N+L+1 (registered path).
- Full: occupancy == DEPTH forces credits = 0 → imem_req = 0. The FIFO never overflows by construction. An rvalid with outstanding == 0 is a bus protocol error; it is ignored and, in simulation, flagged by assertion.
- Simultaneous enqueue and dequeue at full: legal only because credit prevents it. Simultaneous enqueue and dequeue at 0 < occupancy < DEPTH: occupancy unchanged.
- Flush (cycle F):
  - next edge: FIFO emptied and PC-tag queue cleared;
  - discard = outstanding as seen after this cycle's grant/response updates; a response arriving in cycle F itself is dropped;
  - imem_req = 0 and pc_ready = 0 in cycle F;
  - if_valid = 0 from F+1 until new post-flush data arrives;
  - a dequeue handshake in cycle F still completes for decode.
- Flush while discard > 0: discard is reloaded with the new outstanding count.
- Reset mid-operation: the same as a flush. In addition, all counters are cleared immediately and late responses are ignored, because outstanding = 0 and the error assertion is disabled in the reset cycle.
- Pointers: wrap modulo DEPTH. Occupancy and outstanding counters are $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard == 0 and imem_rvalid, the response drives if_valid/if_instr/if_pc combinationally in the same cycle.
  - If if_ready is also high, the entry is consumed and not written to the FIFO.
  - Otherwise it is written as normal.
  - Latency becomes N+L.
- Undefined: all responses are registered through the FIFO; no combinational path from imem_* to if_*.

Test Plan:
- Reset then streaming: pc_in 0x0,0x4,0x8 with gnt=1, L=1, if_ready=1 → if_pc 0x0,0x4,0x8 in consecutive cycles from cycle 3, with if_instr matching memory. Zero-latency variant at cycle 2 when FETCH_BYPASS_EN is defined.
- Backpressure: if_ready=0, DEPTH=2 → after two grants imem_req=0 and pc_ready=0. Raise if_ready → one credit returns and the next fetch for 0x8 issues the following cycle.
- Grant stall: imem_gnt=0 for 3 cycles with pc_valid=1 → pc_ready=0 and imem_addr held stable. Grant on cycle 4 → exactly one tag is pushed.
- Flush in flight: two outstanding (0x10, 0x14), flush asserted, then pc_in=0x100 → both old responses are dropped and the first if_pc after the flush is 0x100.
- Flush coincident with rvalid and dequeue: entry 0x20 dequeued in the flush cycle and response 0x24 dropped → decode sees 0x20 only, then if_valid=0.
- Reset mid-stream with one response outstanding, then rvalid arrives → ignored; if_valid stays 0 and occupancy stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction fetch with tag queue and output FIFO.
// Optional macro FETCH_BYPASS_EN: same-cycle bypass of responses into decode.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [XLEN-1:0] tag_q [DEPTH];
  logic [XLEN-1:0] ins_q [DEPTH];
  logic [XLEN-1:0] pcs_q [DEPTH];
  ptr_t tag_wp, tag_rp, fq_wp, fq_rp;
  cnt_t occ, outst, discard, outst_nx;
  logic [CW:0] used;
  logic grant, resp, keep, enq, deq, pop;
  logic [XLEN-1:0] tag_head;

  assign used      = {1'b0, occ} + {1'b0, outst};
  assign imem_req  = pc_valid & ~flush & ~reset
                   & (used < {1'b0, DEPTH_C});
  assign imem_addr = {pc_in[XLEN-1:2], 2'b00};
  assign grant     = imem_req & imem_gnt;
  assign pc_ready  = grant;
  assign resp      = imem_rvalid & (outst != '0) & ~reset;
  assign keep      = resp & (discard == '0) & ~flush;
  assign tag_head  = tag_q[tag_rp];

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp      = keep & (occ == '0);
  assign if_valid = (occ != '0) | byp;
  assign if_instr = byp ? imem_rdata : ins_q[fq_rp];
  assign if_pc    = byp ? tag_head : pcs_q[fq_rp];
  assign deq      = if_valid & if_ready;
  assign pop      = deq & ~byp;
  assign enq      = keep & ~(byp & if_ready);
`else
  assign if_valid = (occ != '0);
  assign if_instr = ins_q[fq_rp];
  assign if_pc    = pcs_q[fq_rp];
  assign deq      = if_valid & if_ready;
  assign pop      = deq;
  assign enq      = keep;
`endif

  assign outst_nx = outst + cnt_t'(grant) - cnt_t'(resp);

  // Output FIFO: capture kept responses with their tags, drain to decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      fq_wp <= '0;
      fq_rp <= '0;
      occ   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else if (flush) begin
      fq_wp <= '0;
      fq_rp <= '0;
      occ   <= '0;
    end else begin
      if (enq) begin
        ins_q[fq_wp] <= imem_rdata;
        pcs_q[fq_wp] <= tag_head;
        fq_wp        <= fq_wp + ptr_t'(1);
      end
      if (pop) fq_rp <= fq_rp + ptr_t'(1);
      occ <= occ + cnt_t'(enq) - cnt_t'(pop);
    end
  end

  // PC-tag queue: one tag per granted request, popped by kept responses.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tag_wp <= '0;
      tag_rp <= '0;
    end else begin
      if (grant) begin
        tag_q[tag_wp] <= pc_in;
        tag_wp        <= tag_wp + ptr_t'(1);
      end
      if (keep) tag_rp <= tag_rp + ptr_t'(1);
    end
  end

  // In-flight and discard counters; flush turns all in-flight into drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst   <= '0;
      discard <= '0;
    end else begin
      outst <= outst_nx;
      if (flush)
        discard <= outst_nx;
      else if (resp && discard != '0)
        discard <= discard - cnt_t'(1);
    end
  end

  a_no_stray_rvalid: assert property (
    @(posedge clk) disable iff (reset)
    imem_rvalid |-> (outst != '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed checks of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clk = 0;
  logic reset = 1, pc_valid = 0, flush = 0;
  logic imem_gnt = 0, imem_rvalid = 0, if_ready = 0;
  logic [31:0] pc_in = '0, imem_rdata = '0;
  logic pc_ready, imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in),
    .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic s_rst = 1, s_pcv = 0, s_fl = 0;
  logic s_gnt = 0, s_rdy = 0;
  logic [31:0] s_pc = '0;
  int s_rvm = 0;

  logic [63:0] m_fifo[$];
  logic [32:0] m_infl[$];
  logic [31:0] p_addr[$];
  int p_cyc[$];
  logic m_grant = 0;

  logic o_req, o_rdy, o_vld;
  logic [31:0] o_pc, o_ins, o_addr;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_check(input logic rv);
    int credits;
    logic er, gr, kept, ev;
    logic [63:0] ent;
    logic [32:0] fr;
    o_req = imem_req; o_rdy = pc_ready; o_vld = if_valid;
    o_pc = if_pc; o_ins = if_instr; o_addr = imem_addr;
    m_grant = 0;
    if (reset) begin
      chk("req_in_reset", imem_req, 0);
      chk("pc_ready_in_reset", pc_ready, 0);
      m_fifo.delete(); m_infl.delete();
      p_addr.delete(); p_cyc.delete();
      return;
    end
    credits = DEPTH - m_fifo.size() - m_infl.size();
    er = pc_valid && !flush && credits > 0;
    gr = er && imem_gnt;
    m_grant = gr;
    chk("imem_req", imem_req, er);
    chk("pc_ready", pc_ready, gr);
    if (er) chk("imem_addr", imem_addr, {pc_in[31:2], 2'b00});
    kept = 0;
    fr = '0;
    if (rv) begin
      fr = m_infl.pop_front();
      void'(p_addr.pop_front());
      void'(p_cyc.pop_front());
      kept = !fr[32] && !flush;
    end
    ev = m_fifo.size() > 0;
    ent = ev ? m_fifo[0] : '0;
`ifdef FETCH_BYPASS_EN
    if (!ev && kept) begin
      ev = 1;
      ent = {imem_rdata, fr[31:0]};
    end
`endif
    chk("if_valid", if_valid, ev);
    if (ev) begin
      chk("if_instr", if_instr, ent[63:32]);
      chk("if_pc", if_pc, ent[31:0]);
    end
    if (ev && if_ready) begin
      if (m_fifo.size() > 0) void'(m_fifo.pop_front());
      else kept = 0;
    end
    if (kept) m_fifo.push_back({imem_rdata, fr[31:0]});
    if (flush) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i][32] = 1'b1;
    end
    if (gr) begin
      m_infl.push_back({1'b0, pc_in});
      p_addr.push_back({pc_in[31:2], 2'b00});
      p_cyc.push_back(cyc);
    end
  endtask

  task automatic step();
    logic rv;
    @(posedge clk);
    #1;
    rv = 0;
    if (p_addr.size() > 0 && p_cyc[0] < cyc)
      rv = (s_rvm == 1) || (s_rvm == 2 && $urandom_range(1) == 1);
    reset = s_rst; pc_valid = s_pcv; pc_in = s_pc;
    flush = s_fl; imem_gnt = s_gnt; if_ready = s_rdy;
    imem_rvalid = rv;
    imem_rdata = rv ? memw(p_addr[0]) : $urandom;
    @(negedge clk);
    model_check(rv);
    cyc++;
  endtask

  task automatic idle(input int n);
    s_rst = 0; s_pcv = 0; s_fl = 0; s_rdy = 1; s_rvm = 1;
    repeat (n) step();
  endtask

  task automatic reset_dut();
    s_rst = 1; s_pcv = 0; s_fl = 0; s_rdy = 1; s_rvm = 1;
    step();
    s_rst = 0;
    step();
  endtask

  initial begin
    int first_t, grants, hits;
    logic [31:0] seen[$];

    // reset state
    s_gnt = 1; s_rdy = 1; s_rvm = 1;
    reset_dut();
    chk("rst_if_valid", o_vld, 0);
    chk("rst_if_pc", o_pc, 0);
    chk("rst_if_instr", o_ins, 0);
    chk("rst_imem_req", o_req, 0);
    chk("rst_pc_ready", o_rdy, 0);

    // streaming 0x0, 0x4, 0x8 with L=1
    s_pc = 0; first_t = -1;
    for (int t = 1; t <= 10; t++) begin
      s_pcv = (s_pc <= 32'h8);
      step();
      if (m_grant) s_pc += 4;
      if (o_vld) begin
        if (first_t < 0) first_t = t;
        seen.push_back(o_pc);
        chk("stream_instr", o_ins, memw(o_pc));
      end
    end
`ifdef FETCH_BYPASS_EN
    chk("stream_first_cycle", first_t, 2);
`else
    chk("stream_first_cycle", first_t, 3);
`endif
    chk("stream_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("stream_pc0", seen[0], 32'h0);
      chk("stream_pc1", seen[1], 32'h4);
      chk("stream_pc2", seen[2], 32'h8);
    end
    idle(4);

    // backpressure with DEPTH=2
    reset_dut();
    s_rdy = 0; s_pc = 0; s_pcv = 1; s_gnt = 1; s_rvm = 1; grants = 0;
    repeat (6) begin
      step();
      if (m_grant) begin grants++; s_pc += 4; end
    end
    chk("bp_grants", grants, 2);
    chk("bp_req_full", o_req, 0);
    chk("bp_pc_ready_full", o_rdy, 0);
    s_rdy = 1;
    step();
    chk("bp_req_deq_cycle", o_req, 0);
    s_rdy = 0;
    step();
    chk("bp_refetch", o_rdy, 1);
    chk("bp_refetch_addr", o_addr, 32'h8);
    idle(8);

    // grant stall on unaligned pc
    reset_dut();
    s_pc = 32'h206; s_pcv = 1; s_gnt = 0; s_rdy = 1; s_rvm = 1;
    repeat (3) begin
      step();
      chk("stall_pc_ready", o_rdy, 0);
      chk("stall_addr", o_addr, 32'h204);
    end
    s_gnt = 1;
    step();
    chk("stall_grant", o_rdy, 1);
    s_pcv = 0; hits = 0;
    repeat (6) begin
      step();
      if (o_vld && o_pc == 32'h206) hits++;
    end
    chk("stall_one_tag", hits, 1);

    // flush with two requests in flight
    reset_dut();
    s_rvm = 0; s_gnt = 1; s_pcv = 1; s_rdy = 1;
    s_pc = 32'h10; step();
    s_pc = 32'h14; step();
    s_pcv = 0; s_fl = 1; step();
    chk("flush_req", o_req, 0);
    s_fl = 0; s_pc = 32'h100; s_pcv = 1; s_rvm = 1; first_t = -1;
    for (int t = 0; t < 12; t++) begin
      step();
      if (m_grant) s_pcv = 0;
      if (o_vld && first_t < 0) begin
        first_t = t;
        chk("flush_first_pc", o_pc, 32'h100);
      end
    end
    chk("flush_saw_data", first_t >= 0, 1);

    // flush coincident with dequeue and a dropped response
    reset_dut();
    s_rdy = 0; s_pcv = 1; s_gnt = 1;
    s_rvm = 0; s_pc = 32'h20; step();
    s_rvm = 1; s_pc = 32'h24; step();
    s_pcv = 0; s_fl = 1; s_rdy = 1; step();
    chk("fc_deq_valid", o_vld, 1);
    chk("fc_deq_pc", o_pc, 32'h20);
    s_fl = 0;
    repeat (3) begin
      step();
      chk("fc_after_valid", o_vld, 0);
    end

    // reset mid-stream with a late response in the reset cycle
    reset_dut();
    s_pcv = 1; s_pc = 32'h40; s_rvm = 0; s_gnt = 1; step();
    s_pcv = 0; s_rst = 1; s_rvm = 1; step();
    s_rst = 0;
    repeat (3) begin
      step();
      chk("mr_if_valid", o_vld, 0);
    end
    s_pcv = 1; s_gnt = 0; step();
    chk("mr_credit_full", o_req, 1);
    idle(4);

    // randomized traffic
    s_rvm = 2; s_pc = $urandom;
    repeat (4000) begin
      s_rst = ($urandom_range(199) == 0);
      s_fl  = ($urandom_range(29) == 0);
      s_pcv = ($urandom_range(9) < 8);
      s_gnt = ($urandom_range(9) < 6);
      s_rdy = ($urandom_range(9) < 7);
      step();
      if (m_grant) s_pc += 4;
      if (s_fl) s_pc = $urandom;
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
